// File: rtl/oled_pkg.sv
// Shared OLED definitions: the contrast-sequencer state encoding, the
// SSD1306 set-contrast opcode and the default contrast level table.
package oled_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND_CMD = 2'd1,
        ST_SEND_VAL = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    localparam logic [7:0] CMD_CONTRAST_DEF = 8'h81;
    localparam logic [7:0] CONTRAST_RST     = 8'hFF;

    // Element [0] is the first level selected after reset.
    localparam logic [3:0][7:0] LEVEL_TABLE_DEF = {8'hFF, 8'h9F, 8'h5F, 8'h1F};

endpackage

// File: rtl/btn_contrast_seq.sv
// Button-driven contrast stepper: each accepted press sends the two-byte
// SSD1306 set-contrast command (opcode, level) through a valid/ready byte port.
module btn_contrast_seq
    import oled_pkg::*;
#(
    parameter logic [7:0]              CMD_CONTRAST = CMD_CONTRAST_DEF,
    parameter int                      NLEVELS      = 4,
    parameter logic [NLEVELS-1:0][7:0] LEVELS       = LEVEL_TABLE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       press,
    input  logic       init_done,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       tx_dc,
    output logic [7:0] contrast,
    output logic       busy,
    output logic [1:0] state_dbg
);

    // Handshake: a byte moves on any rising edge where tx_valid and tx_ready
    // are both high; while tx_valid is high and tx_ready low, tx_data holds.

    localparam int              IDX_W   = (NLEVELS > 1) ? $clog2(NLEVELS) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NLEVELS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pend_q, pend_d;
    logic [7:0]       contrast_q, contrast_d;
    logic             accept;

    assign accept = press & init_done;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pend_d     = pend_q;
        contrast_d = contrast_q;
        // Any press seen outside IDLE (including the DONE->IDLE cycle) is
        // queued one-deep; extra presses saturate into the same flag.
        if (state_q != ST_IDLE) begin
            pend_d = pend_q | accept;
        end
        case (state_q)
            ST_IDLE: begin
                if (pend_q || accept) begin
                    state_d = ST_SEND_CMD;
                    idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
                    // Consuming a pending press while a fresh one arrives keeps one queued.
                    pend_d  = pend_q & accept;
                end
            end
            ST_SEND_CMD: begin
                if (tx_ready) begin
                    state_d = ST_SEND_VAL;
                end
            end
            ST_SEND_VAL: begin
                if (tx_ready) begin
                    contrast_d = LEVELS[idx_q];
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= IDX_MAX;
            pend_q     <= 1'b0;
            contrast_q <= CONTRAST_RST;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            contrast_q <= contrast_d;
        end
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            ST_SEND_CMD: begin
                tx_valid = 1'b1;
                tx_data  = CMD_CONTRAST;
            end
            ST_SEND_VAL: begin
                tx_valid = 1'b1;
                tx_data  = LEVELS[idx_q];
            end
            default: begin
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
        endcase
    end

    assign tx_dc     = 1'b0;
    assign contrast  = contrast_q;
    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_btn_contrast_seq.sv
// Self-checking bench for btn_contrast_seq: expected bytes are queued when a
// press is issued and a negedge monitor pops them on every handshake.
module tb_btn_contrast_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       press;
    logic       init_done;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_dc;
    logic [7:0] contrast;
    logic       busy;
    logic [1:0] state_dbg;

    logic [8:0] exp_q[$];   // {dc, data}
    int checks = 0;
    int errors = 0;

    btn_contrast_seq dut (
        .clk       (clk),
        .rst       (rst),
        .press     (press),
        .init_done (init_done),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_dc     (tx_dc),
        .contrast  (contrast),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %0h expected none", tx_data);
            end else begin
                chk("tx_byte", {tx_dc, tx_data}, exp_q.pop_front());
            end
        end
    end

    // drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_press();
        press = 1'b1;
        tick();
        press = 1'b0;
    endtask

    task automatic push_seq(input logic [7:0] lvl);
        exp_q.push_back({1'b0, 8'h81});
        exp_q.push_back({1'b0, lvl});
    endtask

    // Counts busy cycles until IDLE; bounded.
    task automatic wait_idle(output int nbusy);
        int n;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout: got busy expected idle");
        end
        nbusy = n;
    endtask

    logic [7:0] lvls[5] = '{8'h1F, 8'h5F, 8'h9F, 8'hFF, 8'h1F};

    initial begin
        int nb;
        rst = 1'b1; press = 1'b0; init_done = 1'b1; tx_ready = 1'b1;
        tick();
        do_reset();

        chk("rst_tx_valid", {8'h0, tx_valid}, 9'h0);
        chk("rst_tx_data",  {1'b0, tx_data},  9'h000);
        chk("rst_tx_dc",    {8'h0, tx_dc},    9'h0);
        chk("rst_busy",     {8'h0, busy},     9'h0);
        chk("rst_contrast", {1'b0, contrast}, 9'h0FF);

        // single press, latency and busy length
        push_seq(8'h1F);
        pulse_press();
        chk("latency_tx_valid", {8'h0, tx_valid}, 9'h1);
        wait_idle(nb);
        chk("busy_cycles", 9'(nb), 9'd3);
        chk("contrast_single", {1'b0, contrast}, 9'h01F);

        // five separated presses with wrap
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_seq(lvls[i]);
            pulse_press();
            wait_idle(nb);
            tick();
            chk("contrast_cycle", {1'b0, contrast}, {1'b0, lvls[i]});
        end

        // back-pressure in SEND_CMD
        do_reset();
        tx_ready = 1'b0;
        push_seq(8'h1F);
        pulse_press();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {8'h0, tx_valid}, 9'h1);
            chk("stall_data",  {1'b0, tx_data},  9'h081);
            chk("stall_state", {7'h0, state_dbg}, 9'd1);
            tick();
        end
        tx_ready = 1'b1;
        wait_idle(nb);
        chk("contrast_stall", {1'b0, contrast}, 9'h01F);

        // three presses while busy: exactly one extra sequence
        do_reset();
        push_seq(8'h1F);
        push_seq(8'h5F);
        pulse_press();
        pulse_press();
        pulse_press();
        pulse_press();
        for (int i = 0; i < 12; i++) tick();
        chk("pend_contrast", {1'b0, contrast}, 9'h05F);
        chk("pend_idle",     {8'h0, busy},     9'h0);
        chk("pend_drained",  9'(exp_q.size()), 9'd0);

        // press with init_done low is discarded
        do_reset();
        init_done = 1'b0;
        pulse_press();
        for (int i = 0; i < 4; i++) tick();
        chk("noinit_busy",     {8'h0, busy},     9'h0);
        chk("noinit_contrast", {1'b0, contrast}, 9'h0FF);
        init_done = 1'b1;
        push_seq(8'h1F);
        pulse_press();
        wait_idle(nb);
        chk("init_contrast", {1'b0, contrast}, 9'h01F);

        // reset during SEND_VAL
        do_reset();
        exp_q.push_back({1'b0, 8'h81});
        pulse_press();
        tick();
        chk("in_send_val", {7'h0, state_dbg}, 9'd2);
        tx_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_valid",    {8'h0, tx_valid}, 9'h0);
        chk("rstmid_busy",     {8'h0, busy},     9'h0);
        chk("rstmid_contrast", {1'b0, contrast}, 9'h0FF);
        tx_ready = 1'b1;
        push_seq(8'h1F);
        pulse_press();
        wait_idle(nb);
        chk("after_rst_contrast", {1'b0, contrast}, 9'h01F);

        tick();
        chk("final_drained", 9'(exp_q.size()), 9'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
